// File: rtl/bfly_r2_sdf.sv
// Radix-2 SDF butterfly stage: sums leave one cycle after the input, and differences are buffered and drained afterwards.
// Optional BFLY_SDF_PROTO_CHECK_EN adds a sticky proto_err flag for bfly_valid seen during DRAIN.
module bfly_r2_sdf #(
  parameter int DATA_WIDTH = 9,
  parameter int MEM_DEPTH  = 128
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] din_re        [0:15],
  input  logic signed [DATA_WIDTH-1:0] din_im        [0:15],
  input  logic signed [DATA_WIDTH-1:0] shift_data_re [0:15],
  input  logic signed [DATA_WIDTH-1:0] shift_data_im [0:15],
  input  logic                         bfly_valid,
  output logic signed [DATA_WIDTH:0]   dout_re       [0:15],
  output logic signed [DATA_WIDTH:0]   dout_im       [0:15],
`ifdef BFLY_SDF_PROTO_CHECK_EN
  output logic                         proto_err,
`endif
  output logic                         dout_valid
);

  localparam int PHASE_LENGTH = MEM_DEPTH / 16;
  localparam int PTR_W        = (PHASE_LENGTH > 1) ? $clog2(PHASE_LENGTH) : 1;

  typedef enum logic [1:0] {IDLE, BFLY, DRAIN} state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   wr_ptr, wr_ptr_nxt;
  logic [PTR_W-1:0]   rd_ptr, rd_ptr_nxt;
  logic               wr_en, rd_en;

  logic signed [DATA_WIDTH:0] sum_re  [0:15];
  logic signed [DATA_WIDTH:0] sum_im  [0:15];
  logic signed [DATA_WIDTH:0] diff_re [0:15];
  logic signed [DATA_WIDTH:0] diff_im [0:15];

  logic signed [DATA_WIDTH:0] diff_buf_re [PHASE_LENGTH][0:15];
  logic signed [DATA_WIDTH:0] diff_buf_im [PHASE_LENGTH][0:15];

  // Explicit sign extension to DATA_WIDTH+1 keeps the sum/difference exact.
  always_comb begin
    for (int unsigned k = 0; k < 16; k++) begin
      sum_re[k]  = {shift_data_re[k][DATA_WIDTH-1], shift_data_re[k]}
                 + {din_re[k][DATA_WIDTH-1], din_re[k]};
      sum_im[k]  = {shift_data_im[k][DATA_WIDTH-1], shift_data_im[k]}
                 + {din_im[k][DATA_WIDTH-1], din_im[k]};
      diff_re[k] = {shift_data_re[k][DATA_WIDTH-1], shift_data_re[k]}
                 - {din_re[k][DATA_WIDTH-1], din_re[k]};
      diff_im[k] = {shift_data_im[k][DATA_WIDTH-1], shift_data_im[k]}
                 - {din_im[k][DATA_WIDTH-1], din_im[k]};
    end
  end

  always_comb begin
    state_nxt  = state;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    case (state)
      IDLE, BFLY: begin
        if (bfly_valid) begin
          wr_en = 1'b1;
          if (wr_ptr == PTR_W'(PHASE_LENGTH - 1)) begin
            wr_ptr_nxt = '0;
            state_nxt  = DRAIN;
          end else begin
            wr_ptr_nxt = wr_ptr + PTR_W'(1);
            state_nxt  = BFLY;
          end
        end
      end
      DRAIN: begin
        rd_en = 1'b1;
        if (rd_ptr == PTR_W'(PHASE_LENGTH - 1)) begin
          rd_ptr_nxt = '0;
          state_nxt  = IDLE;
        end else begin
          rd_ptr_nxt = rd_ptr + PTR_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      dout_valid <= 1'b0;
      dout_re    <= '{default: '0};
      dout_im    <= '{default: '0};
    end else begin
      state      <= state_nxt;
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      dout_valid <= wr_en | rd_en;
      if (wr_en) begin
        dout_re <= sum_re;
        dout_im <= sum_im;
      end else if (rd_en) begin
        dout_re <= diff_buf_re[rd_ptr];
        dout_im <= diff_buf_im[rd_ptr];
      end
    end
  end

  // Buffer contents need no reset; stale entries are never read before being rewritten.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      diff_buf_re[wr_ptr] <= diff_re;
      diff_buf_im[wr_ptr] <= diff_im;
    end
  end

`ifdef BFLY_SDF_PROTO_CHECK_EN
  logic viol;
  assign viol = (state == DRAIN) && bfly_valid;

  always_ff @(posedge clk) begin
    if (rst)       proto_err <= 1'b0;
    else if (viol) proto_err <= 1'b1;
  end
`endif

endmodule
